// File: rtl/mac_job_driver.sv
// Job sequencer in front of the mac datapath: issues MUL/ACC/SAT/CLR with operands,
// stalls the mac when idle, drains the pipeline and captures the result for a valid/ready port.
module mac_job_driver #(
  parameter int LEN_W = 8,
  parameter int DRAIN = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_sat,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [2:0]       mac_instruction,
  output logic [15:0]      mac_multiplier,
  output logic [15:0]      mac_multiplicand,
  output logic             mac_stall,
  input  logic [31:0]      mac_result,
  input  logic [7:0]       mac_protect,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [7:0]       res_protect,
  output logic             busy
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_ISSUE_Z = 3'd2,
    S_SAT     = 3'd3,
    S_DRAIN   = 3'd4,
    S_CAPTURE = 3'd5,
    S_OUT     = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             job_mode;
  logic [LEN_W-1:0] job_len;
  logic             job_sat;
  logic [LEN_W-1:0] pair_cnt;
  logic [DCW-1:0]   drain_cnt;
  logic [2:0]       instr_nxt;
  logic [15:0]      mult_nxt;
  logic [15:0]      mcand_nxt;
  logic             stall_nxt;
  logic             cmd_fire;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign op_ready  = (state == S_ISSUE) && op_valid;
  assign cmd_fire  = cmd_valid && (state == S_IDLE);

  // Next state and the next values of the registered mac pins.
  always_comb begin
    state_nxt = state;
    instr_nxt = {job_mode, 2'b00};
    mult_nxt  = 16'd0;
    mcand_nxt = 16'd0;
    stall_nxt = 1'b1;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cmd_len == {LEN_W{1'b0}}) ? S_ISSUE_Z : S_ISSUE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (op_valid) begin
          instr_nxt = {job_mode, (pair_cnt == {LEN_W{1'b0}}) ? 2'b01 : 2'b10};
          mult_nxt  = op_a;
          mcand_nxt = op_b;
          stall_nxt = 1'b0;
          if (pair_cnt == job_len - LEN_W'(1)) begin
            state_nxt = job_sat ? S_SAT : S_DRAIN;
          end else begin
            state_nxt = S_ISSUE;
          end
        end else begin
          // operand gap: freeze the mac with its inputs untouched
          instr_nxt = mac_instruction;
          mult_nxt  = mac_multiplier;
          mcand_nxt = mac_multiplicand;
        end
      end
      S_ISSUE_Z: begin
        stall_nxt = 1'b0;
        state_nxt = job_sat ? S_SAT : S_DRAIN;
      end
      S_SAT: begin
        instr_nxt = {job_mode, 2'b11};
        stall_nxt = 1'b0;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        stall_nxt = 1'b0;
        if (drain_cnt == DCW'(DRAIN - 1)) begin
          state_nxt = S_CAPTURE;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      S_CAPTURE: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_OUT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, job registers, counters and registered mac pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      job_mode         <= 1'b0;
      job_len          <= {LEN_W{1'b0}};
      job_sat          <= 1'b0;
      pair_cnt         <= {LEN_W{1'b0}};
      drain_cnt        <= {DCW{1'b0}};
      mac_instruction  <= 3'b000;
      mac_multiplier   <= 16'd0;
      mac_multiplicand <= 16'd0;
      mac_stall        <= 1'b1;
    end else begin
      state            <= state_nxt;
      mac_instruction  <= instr_nxt;
      mac_multiplier   <= mult_nxt;
      mac_multiplicand <= mcand_nxt;
      mac_stall        <= stall_nxt;
      if (cmd_fire) begin
        job_mode <= cmd_mode;
        job_len  <= cmd_len;
        job_sat  <= cmd_sat;
        pair_cnt <= {LEN_W{1'b0}};
      end else if (op_ready) begin
        pair_cnt <= pair_cnt + LEN_W'(1);
      end
      if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt + DCW'(1);
      end else begin
        drain_cnt <= {DCW{1'b0}};
      end
    end
  end

  // Result capture and valid/ready hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid   <= 1'b0;
      res_data    <= 32'd0;
      res_protect <= 8'd0;
    end else if (state == S_CAPTURE) begin
      res_valid   <= 1'b1;
      res_data    <= mac_result;
      res_protect <= mac_protect;
    end else if ((state == S_OUT) && res_ready) begin
      res_valid   <= 1'b0;
    end
  end

endmodule
